// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller: RAM geometry defaults and
// the encoding of the last RAM operation used by the port arbiter.
package ram_fifo_pkg;

  localparam int WIDTH_DEF = 138;
  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = 5;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/fifo_out_buf2.sv
// Two-entry show-ahead buffer that receives prefetched RAM words and presents
// the oldest one on head; capture and pop may happen in the same cycle.
module fifo_out_buf2
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             capture,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             pop,
  output logic [1:0]       cnt,
  output logic [1:0]       cnt_nxt,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] tail;

  always_comb begin
    cnt_nxt = cnt;
    if (capture && !pop) begin
      cnt_nxt = cnt + 2'd1;
    end else if (pop && !capture) begin
      cnt_nxt = cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // A captured word lands in head when head is (or is becoming) free, else in tail.
  always_ff @(posedge clk) begin
    if (capture) begin
      if (cnt == 2'd0 || (cnt == 2'd1 && pop)) begin
        head <= cap_data;
      end else begin
        tail <= cap_data;
      end
    end
    if (pop && cnt == 2'd2) begin
      head <= tail;
    end
  end

endmodule

// File: rtl/ram_138_32_fifo_ctrl.sv
// Runs one single-port synchronous RAM as a FIFO: writer and prefetch reader share
// the port with alternating priority, and a 2-entry buffer presents show-ahead data.
module ram_138_32_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW+1:0]    count,
  output logic             ram_cen,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic [AW:0]   ram_cnt_nxt;
  logic          rd_pend;
  logic          last_op;
  logic [1:0]    buf_cnt;
  logic [1:0]    buf_cnt_nxt;
  logic [AW+1:0] count_nxt;
  logic          space;
  logic          read_req;
  logic          rd_win;
  logic          do_wr;
  logic          do_rd;
  logic          pop_fire;

  // Handshakes: a beat moves on a side exactly when valid & ready are both high at
  // posedge; push_ready is a function of state only, and valid never waits on ready.
  always_comb begin
    space       = ram_cnt < FULL_CNT;
    read_req    = (ram_cnt != '0) && ((buf_cnt + {1'b0, rd_pend}) < 2'd2);
    rd_win      = read_req && (last_op == OP_WR);
    push_ready  = rst_n && space && !rd_win;
    do_wr       = push_valid && push_ready;
    do_rd       = rst_n && read_req && !do_wr;
    pop_fire    = pop_valid && pop_ready;
    ram_cnt_nxt = ram_cnt;
    if (do_wr) begin
      ram_cnt_nxt = ram_cnt + (AW+1)'(1);
    end else if (do_rd) begin
      ram_cnt_nxt = ram_cnt - (AW+1)'(1);
    end
    count_nxt = (AW+2)'(ram_cnt_nxt) + (AW+2)'(do_rd) + (AW+2)'(buf_cnt_nxt);
    ram_cen   = !(do_wr || do_rd);
    ram_wen   = !do_wr;
    ram_addr  = do_wr ? wr_ptr : rd_ptr;
    ram_din   = push_data;
  end

  // Flush drops any in-flight read by clearing rd_pend; RAM contents are left as is.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      last_op <= OP_WR;
      count   <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr  <= wr_ptr + AW'(1);
        last_op <= OP_WR;
      end
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        last_op <= OP_RD;
      end
      ram_cnt <= ram_cnt_nxt;
      rd_pend <= do_rd;
      count   <= count_nxt;
    end
  end

  assign pop_valid = (buf_cnt != 2'd0);

  fifo_out_buf2 #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .capture  (rd_pend),
    .cap_data (ram_dout),
    .pop      (pop_fire),
    .cnt      (buf_cnt),
    .cnt_nxt  (buf_cnt_nxt),
    .head     (pop_data)
  );

endmodule
